skeeball_game: RTL and testbench

SKEEBALL_GAME -- requirements
Module: skeeball_game

---
 rtl/skeeball_if.sv | 36 +++
 rtl/skeeball_game.sv | 189 ++++++++++++++++++
 tb/tb_skeeball_game.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/skeeball_if.sv
// Skee-ball game bus: groups the player-side inputs (new-game request and
// hole sensors) with the game status outputs.
//   start      : new-game request, level-sampled
//   holes[6:0] : hole sensors, bit6=100 .. bit1=10, bit0=gutter
//   score      : current game score in tens of points
//   balls_left : balls remaining in the current game
//   high_score : best completed-game score since reset
//   ball_pulse : one-clock pulse per counted ball
//   playing    : game in progress (ball rolling or sensor lockout)
//   game_over  : game finished, waiting for start
//   new_high   : last finished game set a new high score
// master = cabinet/controller side, slave = game logic side.
interface skeeball_if #(
    parameter int SCORE_W = 10,
    parameter int BALL_W  = 4
);
    logic               start;
    logic [6:0]         holes;
    logic [SCORE_W-1:0] score;
    logic [BALL_W-1:0]  balls_left;
    logic [SCORE_W-1:0] high_score;
    logic               ball_pulse;
    logic               playing;
    logic               game_over;
    logic               new_high;

    modport master (
        output start, holes,
        input  score, balls_left, high_score, ball_pulse, playing, game_over, new_high
    );

    modport slave (
        input  start, holes,
        output score, balls_left, high_score, ball_pulse, playing, game_over, new_high
    );
endinterface

// File: rtl/skeeball_game.sv
// Skee-ball scoring controller.
// Counts one ball per rising sensor edge while a ball may be rolling, adds the
// highest-value hole hit (saturating), ignores the sensors for LOCKOUT clocks
// after each ball, and keeps the best completed-game score.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : skeeball_if slave modport (start/holes in, score and status out)
module skeeball_game #(
    parameter int SCORE_W = 10,
    parameter int BALLS   = 9,
    parameter int BALL_W  = 4,
    parameter int LOCKOUT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    skeeball_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_LOCK = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    // Lockout counter holds at most LOCKOUT-1.
    localparam int LOCK_W = ($clog2(LOCKOUT) > 0) ? $clog2(LOCKOUT) : 1;
    // Sum width covers the largest score plus the largest ball value (10).
    localparam int SUM_W  = ((SCORE_W > 4) ? SCORE_W : 4) + 1;
    localparam logic [SUM_W-1:0] SCORE_MAX = {{(SUM_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

    // Ball value in tens of points, highest hole wins when several rise together.
    function automatic logic [3:0] ball_value(input logic [6:0] hit);
        logic [3:0] val;
        if (hit[6]) begin
            val = 4'd10;
        end else if (hit[5]) begin
            val = 4'd5;
        end else if (hit[4]) begin
            val = 4'd4;
        end else if (hit[3]) begin
            val = 4'd3;
        end else if (hit[2]) begin
            val = 4'd2;
        end else if (hit[1]) begin
            val = 4'd1;
        end else begin
            val = 4'd0;
        end
        return val;
    endfunction

    state_t             state_q,      state_d;
    logic [6:0]         holes_q,      holes_d;
    logic [SCORE_W-1:0] score_q,      score_d;
    logic [BALL_W-1:0]  balls_left_q, balls_left_d;
    logic [SCORE_W-1:0] high_score_q, high_score_d;
    logic               ball_pulse_q, ball_pulse_d;
    logic               playing_q,    playing_d;
    logic               game_over_q,  game_over_d;
    logic               new_high_q,   new_high_d;
    logic [LOCK_W-1:0]  lock_cnt_q,   lock_cnt_d;
    logic               over_first_q, over_first_d;

    logic [6:0]         hit_s;
    logic [SUM_W-1:0]   sum_s;
    logic [SCORE_W-1:0] sat_score_s;

    // Next-state and next-output computation for the whole game.
    always_comb begin
        state_d      = state_q;
        holes_d      = bus.holes;
        score_d      = score_q;
        balls_left_d = balls_left_q;
        high_score_d = high_score_q;
        ball_pulse_d = 1'b0;
        new_high_d   = new_high_q;
        lock_cnt_d   = lock_cnt_q;

        // Only fresh sensor edges count, so a held sensor scores once.
        hit_s = bus.holes & ~holes_q;
        sum_s = SUM_W'(score_q) + SUM_W'(ball_value(hit_s));
        if (sum_s > SCORE_MAX) begin
            sat_score_s = SCORE_MAX[SCORE_W-1:0];
        end else begin
            sat_score_s = sum_s[SCORE_W-1:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d      = ST_PLAY;
                    score_d      = {SCORE_W{1'b0}};
                    balls_left_d = BALL_W'(BALLS);
                    new_high_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (hit_s != 7'd0) begin
                    score_d      = sat_score_s;
                    balls_left_d = balls_left_q - BALL_W'(1);
                    ball_pulse_d = 1'b1;
                    // Last ball ends the game without a lockout.
                    if (balls_left_q == BALL_W'(1)) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d    = ST_LOCK;
                        lock_cnt_d = LOCK_W'(LOCKOUT - 1);
                    end
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_LOCK: begin
                if (lock_cnt_q == {LOCK_W{1'b0}}) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d    = ST_LOCK;
                    lock_cnt_d = lock_cnt_q - LOCK_W'(1);
                end
            end
            ST_OVER: begin
                // High score is judged once, on the first clock spent in OVER.
                if (over_first_q && (score_q > high_score_q)) begin
                    high_score_d = score_q;
                    new_high_d   = 1'b1;
                end else begin
                    high_score_d = high_score_q;
                end
                if (bus.start) begin
                    state_d      = ST_PLAY;
                    score_d      = {SCORE_W{1'b0}};
                    balls_left_d = BALL_W'(BALLS);
                    new_high_d   = 1'b0;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        over_first_d = (state_q != ST_OVER) && (state_d == ST_OVER);
        playing_d    = (state_d == ST_PLAY) || (state_d == ST_LOCK);
        game_over_d  = (state_d == ST_OVER);
    end

    // Game state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            holes_q      <= 7'd0;
            score_q      <= {SCORE_W{1'b0}};
            balls_left_q <= {BALL_W{1'b0}};
            high_score_q <= {SCORE_W{1'b0}};
            ball_pulse_q <= 1'b0;
            playing_q    <= 1'b0;
            game_over_q  <= 1'b0;
            new_high_q   <= 1'b0;
            lock_cnt_q   <= {LOCK_W{1'b0}};
            over_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            holes_q      <= holes_d;
            score_q      <= score_d;
            balls_left_q <= balls_left_d;
            high_score_q <= high_score_d;
            ball_pulse_q <= ball_pulse_d;
            playing_q    <= playing_d;
            game_over_q  <= game_over_d;
            new_high_q   <= new_high_d;
            lock_cnt_q   <= lock_cnt_d;
            over_first_q <= over_first_d;
        end
    end

    assign bus.score      = score_q;
    assign bus.balls_left = balls_left_q;
    assign bus.high_score = high_score_q;
    assign bus.ball_pulse = ball_pulse_q;
    assign bus.playing    = playing_q;
    assign bus.game_over  = game_over_q;
    assign bus.new_high   = new_high_q;

endmodule

// File: tb/tb_skeeball_game.sv
// Self-checking bench for skeeball_game: a default-parameter instance and a
// SCORE_W=4 instance receive identical stimulus and are compared against a
// game-level reference model (time-stamped lockout, ball counts, scores).
module tb_skeeball_game;

    localparam int LOCKOUT = 4;

    logic clk;
    logic rst_n;

    skeeball_if #(.SCORE_W(10), .BALL_W(4)) bus ();
    skeeball_if #(.SCORE_W(4),  .BALL_W(4)) sbus ();

    skeeball_game #(.SCORE_W(10), .BALLS(9), .BALL_W(4), .LOCKOUT(LOCKOUT)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    skeeball_game #(.SCORE_W(4), .BALLS(9), .BALL_W(4), .LOCKOUT(LOCKOUT)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors;
    int miscompares;

    // Reference model: index 0 = default instance, 1 = SCORE_W=4 instance.
    int         cyc;
    logic [6:0] m_prev;
    int         m_score[2];
    int         m_balls[2];
    int         m_high[2];
    bit         m_active[2];
    bit         m_over[2];
    bit         m_nh[2];
    bit         m_pulse[2];
    int         m_play_from[2];
    int         m_end_cyc[2];

    function automatic int smax(input int k);
        return (k == 0) ? 1023 : 15;
    endfunction

    task automatic model_reset();
        m_prev = 7'd0;
        for (int k = 0; k < 2; k++) begin
            m_score[k] = 0; m_balls[k] = 0; m_high[k] = 0;
            m_active[k] = 1'b0; m_over[k] = 1'b0; m_nh[k] = 1'b0; m_pulse[k] = 1'b0;
            m_play_from[k] = 0; m_end_cyc[k] = -10;
        end
    endtask

    // One clock edge worth of game rules, applied to the inputs seen at that edge.
    task automatic model_step(input logic s, input logic [6:0] h);
        logic [6:0] rise;
        int         val;
        cyc++;
        rise   = h & ~m_prev;
        m_prev = h;
        val = rise[6] ? 10 : rise[5] ? 5 : rise[4] ? 4 : rise[3] ? 3 :
              rise[2] ? 2 : rise[1] ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            m_pulse[k] = 1'b0;
            if (m_over[k] && (cyc == m_end_cyc[k] + 1) && (m_score[k] > m_high[k])) begin
                m_high[k] = m_score[k];
                m_nh[k]   = 1'b1;
            end
            if (!m_active[k]) begin
                if (s) begin
                    m_active[k] = 1'b1; m_over[k] = 1'b0; m_nh[k] = 1'b0;
                    m_score[k] = 0; m_balls[k] = 9; m_play_from[k] = cyc + 1;
                end
            end else if ((cyc >= m_play_from[k]) && (rise != 7'd0)) begin
                m_score[k] = (m_score[k] + val > smax(k)) ? smax(k) : m_score[k] + val;
                m_balls[k] = m_balls[k] - 1;
                m_pulse[k] = 1'b1;
                if (m_balls[k] == 0) begin
                    m_active[k] = 1'b0; m_over[k] = 1'b1; m_end_cyc[k] = cyc;
                end else begin
                    m_play_from[k] = cyc + LOCKOUT + 1;
                end
            end
        end
    endtask

    // Drive inputs, take one clock edge, sample just after it, advance the model.
    task automatic tick(input logic s, input logic [6:0] h);
        bus.start = s;  bus.holes = h;
        sbus.start = s; sbus.holes = h;
        @(posedge clk);
        #1;
        model_step(s, h);
    endtask

    task automatic play_ball(input logic [6:0] h);
        tick(1'b0, h);
        repeat (5) tick(1'b0, 7'd0);
    endtask

    task automatic finish_game();
        int n;
        n = 0;
        while (!bus.game_over && n < 40) begin
            play_ball(7'b0000001);
            n++;
        end
        vectors++;
        if (!bus.game_over) begin
            miscompares++;
            $display("FAIL finish_game: game_over=%0b required 1 after %0d balls", bus.game_over, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;  bus.holes = 7'h7f;
        sbus.start = 1'b0; sbus.holes = 7'h7f;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({bus.score, bus.balls_left, bus.high_score, bus.ball_pulse, bus.playing,
             bus.game_over, bus.new_high} !== 28'd0) begin
            miscompares++;
            $display("FAIL reset_default: got %h required 0", {bus.score, bus.balls_left,
                     bus.high_score, bus.ball_pulse, bus.playing, bus.game_over, bus.new_high});
        end
        vectors++;
        if ({sbus.score, sbus.balls_left, sbus.high_score, sbus.ball_pulse, sbus.playing,
             sbus.game_over, sbus.new_high} !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_small: got %h required 0", {sbus.score, sbus.balls_left,
                     sbus.high_score, sbus.ball_pulse, sbus.playing, sbus.game_over, sbus.new_high});
        end
        rst_n = 1'b1;
        model_reset();
        cyc = 0;
        // Sensors held through reset are not a rising edge in IDLE.
        tick(1'b0, 7'h7f);
        tick(1'b0, 7'd0);
        vectors++;
        if (bus.score !== 10'd0 || bus.playing !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_hits: score=%0d playing=%0b required 0 0", bus.score, bus.playing);
        end
    endtask

    task automatic test_full_game();
        tick(1'b1, 7'd0);
        vectors++;
        if (bus.playing !== 1'b1 || bus.balls_left !== 4'd9 || bus.score !== 10'd0) begin
            miscompares++;
            $display("FAIL start: playing=%0b balls=%0d score=%0d required 1 9 0",
                     bus.playing, bus.balls_left, bus.score);
        end
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, 7'b1000000);
            vectors++;
            if (bus.score !== 10'(10 * (i + 1)) || bus.balls_left !== 4'(8 - i) || bus.ball_pulse !== 1'b1) begin
                miscompares++;
                $display("FAIL ball_%0d: score=%0d balls=%0d pulse=%0b required %0d %0d 1",
                         i, bus.score, bus.balls_left, bus.ball_pulse, 10 * (i + 1), 8 - i);
            end
            vectors++;
            if (sbus.score !== ((i == 0) ? 4'd10 : 4'd15)) begin
                miscompares++;
                $display("FAIL saturate_%0d: score=%0d required %0d", i, sbus.score, (i == 0) ? 10 : 15);
            end
            for (int j = 0; j < 5; j++) begin
                if (i == 8 && j == 0) begin
                    vectors++;
                    if (bus.game_over !== 1'b1 || bus.high_score !== 10'd0 || bus.playing !== 1'b0) begin
                        miscompares++;
                        $display("FAIL game_end: game_over=%0b high=%0d playing=%0b required 1 0 0",
                                 bus.game_over, bus.high_score, bus.playing);
                    end
                end
                tick(1'b0, 7'd0);
                if (i == 8 && j == 0) begin
                    vectors++;
                    if (bus.high_score !== 10'd90 || bus.new_high !== 1'b1 || bus.ball_pulse !== 1'b0) begin
                        miscompares++;
                        $display("FAIL high_update: high=%0d new_high=%0b pulse=%0b required 90 1 0",
                                 bus.high_score, bus.new_high, bus.ball_pulse);
                    end
                    vectors++;
                    if (sbus.high_score !== 4'd15) begin
                        miscompares++;
                        $display("FAIL small_high: high=%0d required 15", sbus.high_score);
                    end
                end
            end
        end
    endtask

    task automatic test_two_bits();
        tick(1'b1, 7'd0);
        tick(1'b0, 7'b0110000);
        vectors++;
        if (bus.score !== 10'd5 || bus.balls_left !== 4'd8 || bus.ball_pulse !== 1'b1 || bus.new_high !== 1'b0) begin
            miscompares++;
            $display("FAIL two_bits: score=%0d balls=%0d pulse=%0b nh=%0b required 5 8 1 0",
                     bus.score, bus.balls_left, bus.ball_pulse, bus.new_high);
        end
        tick(1'b1, 7'd0);
        vectors++;
        if (bus.ball_pulse !== 1'b0 || bus.balls_left !== 4'd8) begin
            miscompares++;
            $display("FAIL pulse_width: pulse=%0b balls=%0d required 0 8", bus.ball_pulse, bus.balls_left);
        end
        finish_game();
    endtask

    task automatic test_held();
        int pulses;
        pulses = 0;
        tick(1'b1, 7'd0);
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, (c == 2) ? 7'b0001100 : 7'b0001000);
            pulses += int'(bus.ball_pulse);
        end
        tick(1'b0, 7'd0);
        vectors++;
        if (bus.score !== 10'd3 || bus.balls_left !== 4'd8 || pulses != 1) begin
            miscompares++;
            $display("FAIL held_sensor: score=%0d balls=%0d pulses=%0d required 3 8 1",
                     bus.score, bus.balls_left, pulses);
        end
        finish_game();
    endtask

    task automatic test_high_score();
        tick(1'b1, 7'd0);
        for (int i = 0; i < 9; i++) play_ball((i < 5) ? 7'b1000000 : 7'b0000001);
        vectors++;
        if (bus.score !== 10'd50 || bus.high_score !== 10'd90 || bus.new_high !== 1'b0 || bus.game_over !== 1'b1) begin
            miscompares++;
            $display("FAIL lower_game: score=%0d high=%0d nh=%0b over=%0b required 50 90 0 1",
                     bus.score, bus.high_score, bus.new_high, bus.game_over);
        end
        tick(1'b1, 7'd0);
        for (int i = 0; i < 9; i++) play_ball(7'b1000000);
        vectors++;
        if (bus.score !== 10'd90 || bus.high_score !== 10'd90 || bus.new_high !== 1'b0) begin
            miscompares++;
            $display("FAIL equal_game: score=%0d high=%0d nh=%0b required 90 90 0",
                     bus.score, bus.high_score, bus.new_high);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 7'd0);
        for (int i = 0; i < 3; i++) play_ball(7'b1000000);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.score, bus.balls_left, bus.high_score, bus.ball_pulse, bus.playing,
             bus.game_over, bus.new_high} !== 28'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h required 0", {bus.score, bus.balls_left,
                     bus.high_score, bus.ball_pulse, bus.playing, bus.game_over, bus.new_high});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        tick(1'b1, 7'd0);
        vectors++;
        if (bus.balls_left !== 4'd9 || bus.score !== 10'd0 || bus.high_score !== 10'd0 || bus.playing !== 1'b1) begin
            miscompares++;
            $display("FAIL restart: balls=%0d score=%0d high=%0d playing=%0b required 9 0 0 1",
                     bus.balls_left, bus.score, bus.high_score, bus.playing);
        end
    endtask

    task automatic test_random();
        logic [6:0] h;
        logic       s;
        logic [27:0] exp0;
        logic [15:0] exp1;
        h = 7'd0;
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 3))
                0:       h = 7'($urandom);
                1:       h = 7'd0;
                default: h = h;
            endcase
            s = ($urandom_range(0, 7) == 0);
            tick(s, h);
            exp0 = {10'(m_score[0]), 4'(m_balls[0]), 10'(m_high[0]),
                    m_pulse[0], m_active[0], m_over[0], m_nh[0]};
            exp1 = {4'(m_score[1]), 4'(m_balls[1]), 4'(m_high[1]),
                    m_pulse[1], m_active[1], m_over[1], m_nh[1]};
            vectors++;
            if ({bus.score, bus.balls_left, bus.high_score, bus.ball_pulse, bus.playing,
                 bus.game_over, bus.new_high} !== exp0) begin
                miscompares++;
                $display("FAIL random_default cyc %0d: got %h required %h", cyc, {bus.score,
                         bus.balls_left, bus.high_score, bus.ball_pulse, bus.playing,
                         bus.game_over, bus.new_high}, exp0);
            end
            vectors++;
            if ({sbus.score, sbus.balls_left, sbus.high_score, sbus.ball_pulse, sbus.playing,
                 sbus.game_over, sbus.new_high} !== exp1) begin
                miscompares++;
                $display("FAIL random_small cyc %0d: got %h required %h", cyc, {sbus.score,
                         sbus.balls_left, sbus.high_score, sbus.ball_pulse, sbus.playing,
                         sbus.game_over, sbus.new_high}, exp1);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        model_reset();
        test_reset();
        test_full_game();
        test_two_bits();
        test_held();
        test_high_score();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
